handshaking_fifo: RTL
=====================

HANDSHAKING_FIFO -- requirements
Module: handshaking_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_data_in, input, DATA_WIDTH bits: upstream payload.
REQ-006 SHALL have port s_valid_in, input, 1 bit: upstream offers a word.
REQ-007 SHALL have port s_ready_out, output, 1 bit: FIFO can accept a word.
REQ-008 SHALL have port m_data_out, output, DATA_WIDTH bits: head-of-queue payload to the downstream slave.
REQ-009 SHALL have port m_valid_out, output, 1 bit: m_data_out holds a valid word.
REQ-010 SHALL have port m_ready_in, input, 1 bit: downstream slave accepts the word.

Function
REQ-011 SHALL perform a push on each rising edge where s_valid_in=1 and s_ready_out=1; s_data_in is written at the write pointer.
REQ-012 SHALL perform a pop on each rising edge where m_valid_out=1 and m_ready_in=1; the read pointer advances.
REQ-013 SHALL drive s_ready_out=1 exactly when occupancy < DEPTH, and m_valid_out=1 exactly when occupancy > 0.
REQ-014 SHALL present m_data_out as the entry at the read pointer (first-word fall-through); the value is undefined-but-stable when empty.
REQ-015 SHALL have a latency of one cycle: a word pushed at edge N is visible with m_valid_out=1 after edge N; there is no same-cycle pass-through.
REQ-016 SHALL keep m_data_out and m_valid_out stable while m_valid_out=1 and m_ready_in=0.
REQ-017 SHALL, on a simultaneous push and pop with 0 < occupancy < DEPTH, perform both and leave occupancy unchanged.
REQ-018 SHALL, when full, ignore s_valid_in (s_ready_out=0); a pop in that cycle leads to s_ready_out=1 the next cycle.
REQ-019 SHALL, when empty, ignore m_ready_in; a push in that cycle leads to m_valid_out=1 the next cycle.
REQ-020 SHALL wrap pointers from DEPTH-1 to 0; occupancy SHALL be tracked with a log2(DEPTH)+1 bit counter and never exceed DEPTH or go below 0.
REQ-021 SHALL not depend on the upstream holding s_data_in after acceptance; values offered with s_ready_out=0 are not stored.

Reset
REQ-022 SHALL, while rst=0, asynchronously clear the read pointer, write pointer and occupancy to 0.
REQ-023 SHALL drive s_ready_out=1, m_valid_out=0 and m_data_out=0 during reset; storage contents need not be cleared.
REQ-024 SHALL, when reset asserts mid-transfer, discard all stored words; the first push after release lands at entry 0.

Configuration
REQ-025 SHALL, when macro HANDSHAKING_FIFO_COUNT_EN is defined, add output port count_out, log2(DEPTH)+1 bits, equal to the registered occupancy (reset value 0).
REQ-026 SHALL, without HANDSHAKING_FIFO_COUNT_EN, omit count_out entirely; all other behaviour SHALL be identical.

Structure
REQ-027 SHALL take default DATA_WIDTH and DEPTH constants and a clog2 pointer-width helper from shared package handshaking_pkg, also used by the master and slave stages.
REQ-028 SHALL place storage in sub-module handshaking_fifo_mem: a register array with one synchronous write port and one asynchronous read port.
REQ-029 SHALL be instantiable between the handshaking master output and the slave input without glue logic.

Verification
REQ-030 Reset then single word: push 0xA5 with m_ready_in=0 -> m_valid_out=1 one cycle later, m_data_out=0xA5, s_ready_out stays 1.
REQ-031 Fill: push 0x01..0x04 (DEPTH=4) with m_ready_in=0 -> s_ready_out=0 after the 4th push; a 5th offer of 0x05 is not stored; with COUNT_EN, count_out=4.
REQ-032 Drain order: after the fill, hold m_ready_in=1 -> outputs 0x01,0x02,0x03,0x04 on consecutive cycles, then m_valid_out=0.
REQ-033 Streaming: s_valid_in and m_ready_in held at 1 for 20 cycles with an incrementing payload -> one word per cycle, in order, occupancy steady at 1.
REQ-034 Full plus pop: at occupancy 4, assert s_valid_in and m_ready_in together -> pop only; occupancy becomes 3, s_ready_out=1 next cycle.
REQ-035 Mid-operation reset: at occupancy 3, pulse rst=0 between clock edges -> m_valid_out=0 and s_ready_out=1 immediately; a push of 0x3C after release is read back first.

Source files
------------

// File: rtl/handshaking_pkg.sv
// rtl/handshaking_pkg.sv - shared constants and helpers for the handshaking pipeline
//
// Purpose: default payload width and FIFO depth, plus the pointer-width helper
//          used by the master stage, slave stage and handshaking_fifo.
// Ports:   none (package).
package handshaking_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 4;

  // Address bits needed to index `depth` entries; never less than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/handshaking_fifo_mem.sv
// rtl/handshaking_fifo_mem.sv - register-array storage for handshaking_fifo
//
// Purpose: DEPTH x DATA_WIDTH register file, one synchronous write port and
//          one asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk      - write clock
//   wr_en    - write strobe, sampled on the rising edge
//   wr_addr  - write address
//   wr_data  - write payload
//   rd_addr  - read address
//   rd_data  - entry at rd_addr, combinational
module handshaking_fifo_mem
  import handshaking_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_W     = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/handshaking_fifo.sv
// rtl/handshaking_fifo.sv - valid/ready FIFO between handshaking master and slave stages
//
// Purpose: first-word fall-through FIFO with one cycle of push-to-visible
//          latency. Optional occupancy output when HANDSHAKING_FIFO_COUNT_EN
//          is defined.
// Ports:
//   clk         - clock, all state changes on the rising edge
//   rst         - asynchronous active-low reset
//   s_data_in   - upstream payload
//   s_valid_in  - upstream offers a word
//   s_ready_out - FIFO can accept a word (occupancy < DEPTH)
//   m_data_out  - head-of-queue payload (0 when empty)
//   m_valid_out - m_data_out holds a valid word (occupancy > 0)
//   m_ready_in  - downstream accepts the head word
//   count_out   - registered occupancy (only with HANDSHAKING_FIFO_COUNT_EN)
module handshaking_fifo
  import handshaking_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data_in,
  input  logic                  s_valid_in,
  output logic                  s_ready_out,
  output logic [DATA_WIDTH-1:0] m_data_out,
  output logic                  m_valid_out,
  input  logic                  m_ready_in
`ifdef HANDSHAKING_FIFO_COUNT_EN
  ,
  output logic [ptr_width(DEPTH):0] count_out
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] rd_data;

  // Flags derive only from the registered count, so there is no
  // combinational path from s_valid_in to m_valid_out or vice versa.
  assign s_ready_out = (count_q != FULL_COUNT);
  assign m_valid_out = (count_q != '0);
  assign push        = s_valid_in & s_ready_out;
  assign pop         = m_valid_out & m_ready_in;

  // Forcing zero when empty gives the required reset value and keeps the
  // empty-state output stable regardless of stale storage.
  assign m_data_out  = m_valid_out ? rd_data : '0;

`ifdef HANDSHAKING_FIFO_COUNT_EN
  assign count_out = count_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    // push && pop leaves the count unchanged.
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  handshaking_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (s_data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

endmodule
